proc_multi: RTL and testbench
=============================

Name: proc_multi

Overview:
- Parametrised successor of the team's 16-bit-instruction multicycle processor.
- Same FETCH/DECODE/EXECUTE flow against a single shared memory port, plus:
  - configurable data width, register count and PC width;
  - register ADD, register-indirect STORE (drives we), absolute JMP;
  - a hardware output port that replaces simulator prints;
  - a sticky halted flag.
- Sits between the top-level memory model and the testbench.

Parameters:
- DATA_W, 8: register/data width, 1..16.
- REG_AW, 5: register-index width, 1..5; NUM_REGS = 2**REG_AW. Instruction register fields stay 5 bits; only the low REG_AW bits are used.
- PC_W, 8: program counter width, 1..11; PC wraps mod 2**PC_W.
- ADDR_W, 16: memory address width, at least PC_W and at least 11.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-low reset
- fromMem  in  16  memory read data, combinational function of addr in the same cycle
- we  out  1  memory write enable, registered
- addr  out  ADDR_W  memory address, registered
- toMem  out  16  memory write data, registered
- out_valid  out  1  one-cycle strobe: out_data is valid
- out_data  out  DATA_W  emitted value
- halted  out  1  sticky, high after HALT executes

Behaviour:
- Reset: one clock is synchronous and active-low; rst low at a rising clk edge resets the block. State, outputs and registers after reset:
  - state = FETCH, pc = 0, instr = 0;
  - addr = 0, we = 0, toMem = 0;
  - out_valid = 0, out_data = 0, halted = 0;
  - all registers = 0.
- Reset overrides everything, including a store in progress; we drops on that same edge.
- States: FETCH, DECODE, EXECUTE, MEM_READ, MEM_WRITE, HALTED.
  - FETCH: instr <= fromMem (addr holds pc). Next: DECODE.
  - DECODE: no action. Next: EXECUTE.
  - EXECUTE: action per opcode. Next: MEM_READ for LD, MEM_WRITE for ST, HALTED for HALT, otherwise FETCH.
  - MEM_READ: out_data <= fromMem[DATA_W-1:0], out_valid <= 1, addr <= pc+1, pc <= pc+1. Next: FETCH.
  - MEM_WRITE: we is high for exactly this cycle; at its end we <= 0, addr <= pc+1, pc <= pc+1. Next: FETCH.
  - HALTED: absorbing state, exited only by reset. No fetches; addr and pc frozen, we = 0, out_valid = 0.
- Opcode decode in EXECUTE, checked in this order:
  - LI, [15:13]=110: R[[12:8]] <= [7:0], zero-extended or truncated to DATA_W.
  - LD, [15:11]=00001: addr <= zero-extended [10:0]; pc is not advanced here.
  - OUT, [15:11]=00010: out_data <= R[[4:0]], out_valid <= 1.
  - ST, [15:11]=00011: addr <= zero-extended R[[9:5]], toMem <= zero-extended R[[4:0]], we <= 1.
  - ADD, [15:11]=00100: R[[9:5]] <= R[[9:5]] + R[[4:0]], mod 2**DATA_W; same-register operands are allowed.
  - JMP, [15:11]=00101: pc <= [PC_W-1:0], addr <= the same value.
  - HALT, exact word 16'h7777: halted <= 1.
  - Any other encoding: NOP.
- pc advance: LI, OUT, ADD and NOP set addr <= pc+1 and pc <= pc+1 in EXECUTE. HALT freezes pc.
- Latency: 3 cycles for LI, OUT, ADD, JMP and NOP; 4 cycles for LD and ST.
- out_valid is high for one cycle only, in the cycle after the EXECUTE (OUT) or MEM_READ (LD) edge; otherwise 0. out_data holds its last value.
- pc wrap: 2**PC_W-1 + 1 = 0; addr follows.

Optional Feature:
- Macro: INSTR_CNT_EN.
- When defined:
  - extra output port retired, 32 bits;
  - reset to 0;
  - increments by 1 on the edge leaving EXECUTE, MEM_READ or MEM_WRITE, for every completed instruction including HALT and NOP;
  - saturates at 2**32-1.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then mem[0] = 16'hC305 (LI r3,5), mem[1] = 16'h1003 (OUT r3), mem[2] = 16'h7777 -> one out_valid pulse with out_data = 8'h05 in cycle 6 after reset release; halted = 1 after cycle 9; addr stays 2.
- LI r1,8'hF0; LI r2,8'h20; ADD r1,r1,r2 (16'h2022); OUT r1 -> out_data = 8'h10 (wrap); 4 instructions take 12 cycles.
- LI r4,8'h40; LI r5,8'hAB; ST addr r4, data r5 (16'h1885) -> we high exactly 1 cycle with addr = 16'h0040 and toMem = 16'h00AB; next fetch at addr 3.
- LD 11'h7FF (16'h0FFF) with mem[16'h7FF] = 16'h1234 -> out_data = 8'h34 pulse; next fetch at pc 1.
- JMP 8'hFF at mem[0], NOP at mem[255] -> fetch order 0, 255, 0 (wrap); with INSTR_CNT_EN, retired = 2 after the NOP.
- Assert rst low in the MEM_WRITE cycle -> we = 0 and pc = 0 at that edge; execution restarts at addr 0.

Source files
------------

// File: rtl/proc_multi.sv
// proc_multi: parametrised 16-bit-instruction multicycle processor.
// Runs FETCH/DECODE/EXECUTE (+ MEM_READ/MEM_WRITE) against one shared memory
// port, supports LI, LD, OUT, ST, ADD, JMP, HALT; anything else is a NOP.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   fromMem    memory read data (combinational in addr)
//   we         memory write enable (registered)
//   addr       memory address (registered)
//   toMem      memory write data (registered)
//   out_valid  one-cycle strobe qualifying out_data
//   out_data   last emitted value
//   halted     sticky, set once HALT executes
//   retired    completed-instruction count, only with INSTR_CNT_EN defined
// Optional feature macro: INSTR_CNT_EN (saturating 32-bit retired counter).
module proc_multi #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PC_W   = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       fromMem,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       toMem,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              halted
`ifdef INSTR_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    localparam int unsigned NUM_REGS = 2 ** REG_AW;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM_READ, S_MEM_WRITE, S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [15:0]         to_mem_q, to_mem_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                halted_q, halted_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    // Opcode decode; the encodings are mutually exclusive so priority is moot.
    logic op_li, op_ld, op_out, op_st, op_add, op_jmp, op_halt;
    assign op_li   = (instr_q[15:13] == 3'b110);
    assign op_ld   = (instr_q[15:11] == 5'b00001);
    assign op_out  = (instr_q[15:11] == 5'b00010);
    assign op_st   = (instr_q[15:11] == 5'b00011);
    assign op_add  = (instr_q[15:11] == 5'b00100);
    assign op_jmp  = (instr_q[15:11] == 5'b00101);
    assign op_halt = (instr_q == 16'h7777);

    // Register fields are 5 bits in the word; only the low REG_AW bits index.
    logic [REG_AW-1:0] idx_a, idx_b, idx_li;
    logic [DATA_W-1:0] reg_a, reg_b;
    logic [15:0]       li_ext;
    logic [PC_W-1:0]   pc_inc;
    assign idx_a  = instr_q[REG_AW-1:0];
    assign idx_b  = instr_q[5 +: REG_AW];
    assign idx_li = instr_q[8 +: REG_AW];
    assign reg_a  = regs_q[idx_a];
    assign reg_b  = regs_q[idx_b];
    assign li_ext = {8'h00, instr_q[7:0]};
    assign pc_inc = pc_q + PC_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = S_DECODE;
            S_DECODE:    state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (op_ld)        state_d = S_MEM_READ;
                else if (op_st)   state_d = S_MEM_WRITE;
                else if (op_halt) state_d = S_HALTED;
                else              state_d = S_FETCH;
            end
            S_MEM_READ:  state_d = S_FETCH;
            S_MEM_WRITE: state_d = S_FETCH;
            S_HALTED:    state_d = S_HALTED;
            default:     state_d = S_FETCH;
        endcase
    end

    // Output / datapath next values.
    logic advance;
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        to_mem_d    = to_mem_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        halted_d    = halted_q;
        regs_d      = regs_q;
        advance     = 1'b0;
        case (state_q)
            S_FETCH: instr_d = fromMem;
            S_EXECUTE: begin
                if (op_li) begin
                    regs_d[idx_li] = li_ext[DATA_W-1:0];
                    advance        = 1'b1;
                end else if (op_ld) begin
                    addr_d = ADDR_W'(instr_q[10:0]);
                end else if (op_out) begin
                    out_data_d  = reg_a;
                    out_valid_d = 1'b1;
                    advance     = 1'b1;
                end else if (op_st) begin
                    addr_d   = ADDR_W'(reg_b);
                    to_mem_d = 16'(reg_a);
                    we_d     = 1'b1;
                end else if (op_add) begin
                    regs_d[idx_b] = reg_b + reg_a;
                    advance       = 1'b1;
                end else if (op_jmp) begin
                    pc_d   = instr_q[PC_W-1:0];
                    addr_d = ADDR_W'(instr_q[PC_W-1:0]);
                end else if (op_halt) begin
                    halted_d = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            S_MEM_READ: begin
                out_data_d  = fromMem[DATA_W-1:0];
                out_valid_d = 1'b1;
                advance     = 1'b1;
            end
            S_MEM_WRITE: advance = 1'b1;
            default: ;
        endcase
        if (advance) begin
            pc_d   = pc_inc;
            addr_d = ADDR_W'(pc_inc);
        end
    end

    // Datapath registers; reset also cancels a store in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= '0;
            instr_q     <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            to_mem_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            halted_q    <= 1'b0;
            regs_q      <= '{default: '0};
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            to_mem_q    <= to_mem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            halted_q    <= halted_d;
            regs_q      <= regs_d;
        end
    end

    assign we        = we_q;
    assign addr      = addr_q;
    assign toMem     = to_mem_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign halted    = halted_q;

`ifdef INSTR_CNT_EN
    // Count each instruction once, on the edge of its final state.
    logic [31:0] retired_q, retired_d;
    logic        completes;
    always_comb begin
        completes = ((state_q == S_EXECUTE) && !op_ld && !op_st) ||
                    (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
        retired_d = retired_q;
        if (completes && (retired_q != 32'hFFFF_FFFF))
            retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) retired_q <= '0;
        else      retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_proc_multi.sv
// Bench for proc_multi: directed programs, scoreboard of expected out_valid
// pulses and memory writes (value + cycle), checked by a separate monitor.
module tb_proc_multi;

    logic        clk;
    logic        rst;
    logic [15:0] from_mem;
    logic        we;
    logic [15:0] addr;
    logic [15:0] to_mem;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        halted;
`ifdef INSTR_CNT_EN
    logic [31:0] retired;
`endif

    logic [15:0] mem [2048];
    int unsigned cyc;
    int unsigned checks;
    int unsigned failures;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
        logic [31:0] c;
    } ev_t;

    ev_t out_q[$];
    ev_t wr_q[$];

    proc_multi dut (
        .clk      (clk),
        .rst      (rst),
        .fromMem  (from_mem),
        .we       (we),
        .addr     (addr),
        .toMem    (to_mem),
        .out_valid(out_valid),
        .out_data (out_data),
        .halted   (halted)
`ifdef INSTR_CNT_EN
        ,
        .retired  (retired)
`endif
    );

    assign from_mem = mem[addr[10:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release: cyc == k at the negedge after the k-th edge.
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int unsigned k);
        int n = 0;
        while (cyc != k && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != k) begin
            checks++;
            failures++;
            $display("FAIL wait_cyc: reached %0d expected %0d", cyc, k);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h7777;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_we",        32'(we), 32'h0);
        chk("rst_addr",      32'(addr), 32'h0);
        chk("rst_toMem",     32'(to_mem), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data), 32'h0);
        chk("rst_halted",    32'(halted), 32'h0);
        rst = 1'b1;
    endtask

    task automatic push_out(input logic [15:0] d, input int unsigned c);
        out_q.push_back('{a: 16'h0, d: d, c: 32'(c)});
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d, input int unsigned c);
        wr_q.push_back('{a: a, d: d, c: 32'(c)});
    endtask

    task automatic drain_check(input string name);
        chk({name, "_out_pending"}, 32'(out_q.size()), 32'h0);
        chk({name, "_wr_pending"},  32'(wr_q.size()),  32'h0);
        out_q.delete();
        wr_q.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        clear_mem();

        fork
            begin : monitor
                ev_t e;
                forever begin
                    @(negedge clk);
                    if (out_valid === 1'b1) begin
                        if (out_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL out_unexpected: got data %0h expected no pulse (cyc %0d)", out_data, cyc);
                        end else begin
                            e = out_q.pop_front();
                            chk("out_data",  32'(out_data), 32'(e.d));
                            chk("out_cycle", 32'(cyc), e.c);
                        end
                    end
                    if (we === 1'b1) begin
                        if (wr_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL wr_unexpected: got addr %0h expected no write (cyc %0d)", addr, cyc);
                        end else begin
                            e = wr_q.pop_front();
                            chk("wr_addr",  32'(addr), 32'(e.a));
                            chk("wr_data",  32'(to_mem), 32'(e.d));
                            chk("wr_cycle", 32'(cyc), e.c);
                        end
                    end
                end
            end
        join_none

        // LI r3,5; OUT r3; HALT
        clear_mem();
        mem[0] = 16'hC305;
        mem[1] = 16'h1003;
        release_reset();
        push_out(16'h05, 6);
        wait_cyc(8);
        chk("t1_halted_pre", 32'(halted), 32'h0);
        wait_cyc(9);
        chk("t1_halted", 32'(halted), 32'h1);
        chk("t1_addr",   32'(addr), 32'h2);
        wait_cyc(14);
        chk("t1_halted_sticky", 32'(halted), 32'h1);
        chk("t1_addr_frozen",   32'(addr), 32'h2);
        drain_check("t1");

        // LI r1,F0; LI r2,20; ADD r1,r1,r2; OUT r1 -> 0x10
        rst = 1'b0;
        clear_mem();
        mem[0] = 16'hC1F0;
        mem[1] = 16'hC220;
        mem[2] = 16'h2022;
        mem[3] = 16'h1001;
        release_reset();
        push_out(16'h10, 12);
        wait_cyc(12);
        chk("t2_addr", 32'(addr), 32'h4);
        wait_cyc(15);
        chk("t2_halted", 32'(halted), 32'h1);
        drain_check("t2");

        // LI r4,40; LI r5,AB; ST [r4] <- r5
        rst = 1'b0;
        clear_mem();
        mem[0] = 16'hC440;
        mem[1] = 16'hC5AB;
        mem[2] = 16'h1885;
        release_reset();
        push_wr(16'h0040, 16'h00AB, 9);
        wait_cyc(10);
        chk("t3_we_low",    32'(we), 32'h0);
        chk("t3_next_addr", 32'(addr), 32'h3);
        wait_cyc(13);
        chk("t3_halted", 32'(halted), 32'h1);
        drain_check("t3");

        // LD 7FF
        rst = 1'b0;
        clear_mem();
        mem[0]       = 16'h0FFF;
        mem[11'h7FF] = 16'h1234;
        release_reset();
        push_out(16'h34, 4);
        wait_cyc(3);
        chk("t4_ld_addr", 32'(addr), 32'h7FF);
        wait_cyc(4);
        chk("t4_next_addr", 32'(addr), 32'h1);
        wait_cyc(7);
        chk("t4_halted", 32'(halted), 32'h1);
        drain_check("t4");

        // JMP FF; NOP at FF wraps to 0
        rst = 1'b0;
        clear_mem();
        mem[0]   = 16'h28FF;
        mem[255] = 16'h0000;
        release_reset();
        wait_cyc(3);
        chk("t5_jmp_addr", 32'(addr), 32'hFF);
        wait_cyc(6);
        chk("t5_wrap_addr", 32'(addr), 32'h0);
`ifdef INSTR_CNT_EN
        chk("t5_retired", retired, 32'd2);
`endif
        wait_cyc(9);
        chk("t5_loop_addr", 32'(addr), 32'hFF);
        chk("t5_halted", 32'(halted), 32'h0);
        drain_check("t5");

        // Reset during MEM_WRITE cancels the store and restarts at 0
        rst = 1'b0;
        clear_mem();
        mem[0] = 16'hC440;
        mem[1] = 16'hC5AB;
        mem[2] = 16'h1885;
        release_reset();
        push_wr(16'h0040, 16'h00AB, 9);
        wait_cyc(9);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_we_reset",   32'(we), 32'h0);
        chk("t6_addr_reset", 32'(addr), 32'h0);
        rst = 1'b1;
        push_wr(16'h0040, 16'h00AB, 9);
        wait_cyc(3);
        chk("t6_restart_addr", 32'(addr), 32'h1);
        wait_cyc(10);
        chk("t6_next_addr", 32'(addr), 32'h3);
        drain_check("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
